// File: rtl/hpr_fir_if.sv
// Stream, coefficient-write and result signals of the hpr_fir block.
// The master drives samples and coefficient writes; the slave (the filter)
// returns the handshake, error pulse and filtered output.
interface hpr_fir_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
);
  localparam int ADDR_W = $clog2(TAPS);

  // input sample stream
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  // coefficient write port
  logic                     coef_wr_en;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_err;

  // filtered output
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;

  modport master (
    output in_valid, in_data, coef_wr_en, coef_addr, coef_data,
    input  in_ready, coef_err, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_wr_en, coef_addr, coef_data,
    output in_ready, coef_err, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/hpr_fir.sv
// High-pass reconstruction FIR: TAPS-deep delay line, one time-shared MAC,
// runtime-loadable coefficients, round-half-up and saturation on the output,
// optional zero-insertion upsample-by-2 for the synthesis stage.
module hpr_fir #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 8,
  parameter int FRAC     = 14,
  parameter int UPSAMPLE = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clk_enable_i,
  hpr_fir_if.slave bus
);

  localparam int CNT_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + CNT_W;

  localparam logic [CNT_W-1:0]         LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] UNITY    = COEF_W'(64'd1 << FRAC);
  localparam logic signed [ACC_W:0]    RND_HALF = (ACC_W + 1)'(64'd1 << (FRAC - 1));
  localparam logic signed [ACC_W:0]    SAT_MAX  = (ACC_W + 1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0]    SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT,
    S_ZERO
  } state_t;

  state_t                   state_q;
  logic                     phase_q;
  logic signed [DATA_W-1:0] d_q    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         k_q;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_valid_q;
  logic                     sat_q;
  logic                     coef_err_q;
  logic                     in_ready_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] out_sat;
  logic                     sat_hit;
  logic                     addr_ok;

  // Range check done on a widened copy so it stays meaningful when TAPS is not a power of two.
  assign addr_ok = (32'(bus.coef_addr) < 32'(TAPS));

  // MAC datapath for the current tap, plus rounding and clipping of the finished sum.
  always_comb begin
    prod    = d_q[k_q] * coef_q[k_q];
    acc_sum = acc_q + {{CNT_W{prod[PROD_W-1]}}, prod};
    rnd     = {acc_q[ACC_W-1], acc_q} + RND_HALF;
    shifted = rnd >>> FRAC;
    out_sat = shifted[DATA_W-1:0];
    sat_hit = 1'b0;
    if (shifted > SAT_MAX) begin
      out_sat = SAT_MAX[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      out_sat = SAT_MIN[DATA_W-1:0];
      sat_hit = 1'b1;
    end
  end

  // Control FSM with delay line, coefficient bank, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      acc_q       <= '0;
      k_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      coef_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int i = 0; i < TAPS; i++) begin
        d_q[i]    <= '0;
        coef_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else if (clk_enable_i) begin
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;

      // A write landing in IDLE is visible to a sample accepted on the same edge,
      // because the MAC only reads coefficients from the following cycle on.
      if (bus.coef_wr_en) begin
        if (state_q == S_IDLE && addr_ok) begin
          coef_q[bus.coef_addr] <= bus.coef_data;
        end else begin
          coef_err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              d_q[i] <= d_q[i-1];
            end
            d_q[0]     <= bus.in_data;
            acc_q      <= '0;
            k_q        <= '0;
            phase_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_MAC;
          end
        end

        S_MAC: begin
          acc_q <= acc_sum;
          if (k_q == LAST_TAP) begin
            state_q <= S_OUT;
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end

        S_OUT: begin
          out_q       <= out_sat;
          sat_q       <= sat_hit;
          out_valid_q <= 1'b1;
          if (UPSAMPLE != 0 && !phase_q) begin
            state_q <= S_ZERO;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end

        S_ZERO: begin
          // Zero-inserted phase: the inserted zero travels the delay line like a real sample.
          for (int i = TAPS - 1; i > 0; i--) begin
            d_q[i] <= d_q[i-1];
          end
          d_q[0]  <= '0;
          acc_q   <= '0;
          k_q     <= '0;
          phase_q <= 1'b1;
          state_q <= S_MAC;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.coef_err  = coef_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_hpr_fir.sv
// Directed bench for hpr_fir: expectations (value, sat flag, strobe cycle) are
// queued when a sample is driven and checked when out_valid fires.
module tb_hpr_fir;

  logic clk;
  logic rst_n;
  logic clk_enable;

  int n_tests;
  int n_fail;
  int cyc;
  logic last_en;

  typedef struct {
    int val;
    int sat;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  hpr_fir_if #(.DATA_W(16), .COEF_W(16), .TAPS(8)) b0 ();
  hpr_fir_if #(.DATA_W(16), .COEF_W(16), .TAPS(8)) b1 ();
  hpr_fir_if #(.DATA_W(16), .COEF_W(16), .TAPS(5)) b5 ();

  hpr_fir #(.DATA_W(16), .COEF_W(16), .TAPS(8), .FRAC(14), .UPSAMPLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clk_enable_i(clk_enable), .bus(b0)
  );
  hpr_fir #(.DATA_W(16), .COEF_W(16), .TAPS(8), .FRAC(14), .UPSAMPLE(1)) u_up (
    .clk(clk), .rst_n(rst_n), .clk_enable_i(clk_enable), .bus(b1)
  );
  hpr_fir #(.DATA_W(16), .COEF_W(16), .TAPS(5), .FRAC(14), .UPSAMPLE(0)) u5 (
    .clk(clk), .rst_n(rst_n), .clk_enable_i(clk_enable), .bus(b5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    last_en <= clk_enable;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard for the plain instance
  always @(negedge clk) begin
    if (last_en && b0.out_valid) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_strobe", 1, 0);
      end else begin
        e0 = q0.pop_front();
        $display("[TB] u0 out=%0d sat=%0d cyc=%0d (exp %0d/%0d/%0d)",
                 b0.out_data, b0.sat_flag, cyc, e0.val, e0.sat, e0.cyc);
        chk("u0_out", b0.out_data, e0.val);
        chk("u0_sat", b0.sat_flag, e0.sat);
        chk("u0_cycle", cyc, e0.cyc);
      end
    end
  end

  // scoreboard for the upsampling instance
  always @(negedge clk) begin
    if (last_en && b1.out_valid) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_strobe", 1, 0);
      end else begin
        e1 = q1.pop_front();
        $display("[TB] u1 out=%0d sat=%0d cyc=%0d (exp %0d/%0d/%0d)",
                 b1.out_data, b1.sat_flag, cyc, e1.val, e1.sat, e1.cyc);
        chk("u1_out", b1.out_data, e1.val);
        chk("u1_sat", b1.sat_flag, e1.sat);
        chk("u1_cycle", cyc, e1.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", b0.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready0();
    int n = 0;
    while (b0.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("u0_ready_wait", b0.in_ready, 1);
  endtask

  // drive one sample into u0 and queue its expected result
  task automatic send0(input int v, input int ev, input int es, input int extra);
    wait_ready0();
    b0.in_valid = 1'b1;
    b0.in_data  = 16'(v);
    q0.push_back('{ev, es, cyc + 10 + extra});
    @(negedge clk);
    b0.in_valid = 1'b0;
    chk("u0_busy_after_accept", b0.in_ready, 0);
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("u0_drain", q0.size(), 0);
  endtask

  task automatic wcoef0(input int addr, input int data, input int exp_err);
    b0.coef_wr_en = 1'b1;
    b0.coef_addr  = 3'(addr);
    b0.coef_data  = 16'(data);
    @(negedge clk);
    b0.coef_wr_en = 1'b0;
    chk("u0_coef_err", b0.coef_err, exp_err);
  endtask

  task automatic wcoef5(input int addr, input int data, input int exp_err);
    b5.coef_wr_en = 1'b1;
    b5.coef_addr  = 3'(addr);
    b5.coef_data  = 16'(data);
    @(negedge clk);
    b5.coef_wr_en = 1'b0;
    chk("u5_coef_err", b5.coef_err, exp_err);
  endtask

  initial begin
    int n;
    int hits;
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    last_en    = 1'b0;
    clk_enable = 1'b1;
    rst_n      = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.coef_wr_en = 1'b0; b0.coef_addr = '0; b0.coef_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.coef_wr_en = 1'b0; b1.coef_addr = '0; b1.coef_data = '0;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.coef_wr_en = 1'b0; b5.coef_addr = '0; b5.coef_data = '0;

    // reset defaults
    repeat (3) @(negedge clk);
    chk("rst_out", b0.out_data, 0);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_sat", b0.sat_flag, 0);
    chk("rst_coef_err", b0.coef_err, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // pass-through with default coefficients
    send0(100, 100, 0, 0);
    drain0();
    send0(-200, -200, 0, 0);
    drain0();
    repeat (3) @(negedge clk);
    chk("out_holds", b0.out_data, -200);

    // impulse response
    do_reset();
    for (int k = 0; k < 8; k++) wcoef0(k, 1000 * (k + 1), 0);
    send0(16384, 1000, 0, 0);
    for (int k = 1; k < 8; k++) send0(0, 1000 * (k + 1), 0, 0);
    drain0();

    // saturation and rounding
    do_reset();
    wcoef0(0, 32767, 0);
    send0(30000, 32767, 1, 0);
    drain0();
    send0(-30000, -32768, 1, 0);
    drain0();
    wcoef0(0, 8192, 0);
    send0(3, 2, 0, 0);
    drain0();
    send0(-3, -1, 0, 0);
    drain0();

    // coefficient write and accept on the same edge: new value must be used
    wait_ready0();
    b0.coef_wr_en = 1'b1; b0.coef_addr = 3'd0; b0.coef_data = 16'sd16384;
    b0.in_valid   = 1'b1; b0.in_data   = 16'sd77;
    q0.push_back('{77, 0, cyc + 10});
    @(negedge clk);
    b0.coef_wr_en = 1'b0;
    b0.in_valid   = 1'b0;
    chk("same_edge_no_err", b0.coef_err, 0);
    drain0();

    // upsample-by-2: sample phase then zero phase, ready low throughout
    b1.in_valid = 1'b1;
    b1.in_data  = 16'sd500;
    q1.push_back('{500, 0, cyc + 10});
    q1.push_back('{0, 0, cyc + 20});
    @(negedge clk);
    b1.in_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 19; i++) begin
      if (b1.in_ready !== 1'b0) hits++;
      @(negedge clk);
    end
    chk("u1_ready_low", hits, 0);
    n = 0;
    while (q1.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("u1_drain", q1.size(), 0);
    chk("u1_ready_after", b1.in_ready, 1);

    // handshake: in_valid held through MAC, coefficient write while busy
    do_reset();
    b0.in_valid = 1'b1;
    b0.in_data  = 16'sd40;
    q0.push_back('{40, 0, cyc + 10});
    @(negedge clk);
    b0.in_data = 16'sd999;
    chk("busy_in_ready", b0.in_ready, 0);
    b0.coef_wr_en = 1'b1; b0.coef_addr = 3'd0; b0.coef_data = 16'sd0;
    @(negedge clk);
    b0.coef_wr_en = 1'b0;
    chk("busy_coef_err", b0.coef_err, 1);
    @(negedge clk);
    chk("coef_err_one_cycle", b0.coef_err, 0);
    repeat (4) @(negedge clk);
    b0.in_valid = 1'b0;
    drain0();
    repeat (12) @(negedge clk);
    send0(50, 50, 0, 0);
    drain0();

    // out-of-range coefficient address on a non-power-of-two instance
    wcoef5(5, 123, 1);
    wcoef5(7, 123, 1);
    wcoef5(4, 0, 0);

    // clock enable low for five cycles mid-MAC
    send0(1234, 1234, 0, 5);
    repeat (3) @(negedge clk);
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    clk_enable = 1'b1;
    drain0();

    // reset asserted mid-MAC aborts the sample
    wait_ready0();
    b0.in_valid = 1'b1;
    b0.in_data  = 16'sd555;
    @(negedge clk);
    b0.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_in_reset", b0.in_ready, 1);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (b0.out_valid !== 1'b0) hits++;
    end
    chk("abort_no_strobe", hits, 0);
    chk("abort_in_ready_after", b0.in_ready, 1);
    send0(123, 123, 0, 0);
    drain0();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
